param_datapath: RTL and testbench

//   Parametrised successor to the 8-bit datapath: NREGS x WIDTH register file (2 async read, 1 write port)

---
 rtl/dp_pkg.sv | 30 +++
 rtl/param_datapath_if.sv | 48 ++++
 rtl/dp_alu.sv | 74 +++++++
 rtl/param_datapath.sv | 118 +++++++++++
 tb/tb_param_datapath.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_pkg
// Purpose  : Shared constants for the parametrised datapath: ALU opcode
//            encoding, status-flag bit positions and the flag vector width.
// Revision : 1.0  initial release
// ============================================================================
package dp_pkg;

    // ALU opcode encoding
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Status flag vector layout
    localparam int FLAG_W     = 4;
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage : dp_pkg
`default_nettype wire

// File: rtl/param_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : param_datapath_if
// Purpose  : Bundle of the control, address, data and status signals between
//            the sequencer (master) and the parametrised datapath (slave).
// Ports    : master drives alu_en, alu_opcode, user_write_data, write_addr,
//            write_en, ra_addr, rb_addr; slave drives read_a, read_b,
//            wb_data, wb_valid and the four registered ALU flags.
// Revision : 1.0  initial release
// ============================================================================
interface param_datapath_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 16
);
    localparam int AW = $clog2(NREGS);

    logic             alu_en;
    logic [2:0]       alu_opcode;
    logic [WIDTH-1:0] user_write_data;
    logic [AW-1:0]    write_addr;
    logic             write_en;
    logic [AW-1:0]    ra_addr;
    logic [AW-1:0]    rb_addr;
    logic [WIDTH-1:0] read_a;
    logic [WIDTH-1:0] read_b;
    logic [WIDTH-1:0] wb_data;
    logic             wb_valid;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_neg;
    logic             alu_ovf;

    modport master (
        output alu_en, alu_opcode, user_write_data, write_addr, write_en,
               ra_addr, rb_addr,
        input  read_a, read_b, wb_data, wb_valid,
               alu_zero, alu_carry, alu_neg, alu_ovf
    );

    modport slave (
        input  alu_en, alu_opcode, user_write_data, write_addr, write_en,
               ra_addr, rb_addr,
        output read_a, read_b, wb_data, wb_valid,
               alu_zero, alu_carry, alu_neg, alu_ovf
    );

endinterface : param_datapath_if
`default_nettype wire

// File: rtl/dp_alu.sv
`default_nettype none
// ============================================================================
// Module   : dp_alu
// Purpose  : Purely combinational 8-operation ALU, WIDTH bits wide.
// Ports    : a, b    - operands
//            opcode  - operation select (encoding in dp_pkg)
//            result  - WIDTH-bit truncated result
//            flags   - {ovf, neg, carry, zero} at dp_pkg FLAG_* positions
// Revision : 1.0  initial release
// ============================================================================
module dp_alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        opcode,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    // One extra bit holds the carry-out of the add and the borrow of the
    // subtract (the MSB of a zero-extended difference is set iff a < b).
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_carry;
    logic           w_ovf;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result  = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (opcode)
            OP_ADD: begin
                result  = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result  = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result  = {a[WIDTH-2:0], 1'b0};
                w_carry = a[WIDTH-1];
            end
            default: begin // OP_SHR, logical
                result  = {1'b0, a[WIDTH-1:1]};
                w_carry = a[0];
            end
        endcase
    end

    always_comb begin
        flags             = '0;
        flags[FLAG_ZERO]  = (result == '0);
        flags[FLAG_CARRY] = w_carry;
        flags[FLAG_NEG]   = result[WIDTH-1];
        flags[FLAG_OVF]   = w_ovf;
    end

endmodule : dp_alu
`default_nettype wire

// File: rtl/param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : param_datapath
// Purpose  : NREGS x WIDTH register file (2 async read ports, 1 write port)
//            feeding an 8-op ALU. Every write, user or ALU, is captured in a
//            single writeback register on issue and committed one edge later,
//            so write latency is uniformly 2 edges at 1 write per cycle.
//            ALU status flags are registered on ALU issues only.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset (clears registers, pipe,
//                   flags; discards a pending write)
//            bus  - param_datapath_if.slave (control in, reads/status out)
// Config   : DP_BYPASS_EN - when defined, read ports forward the pending
//            writeback data on an address match (RAW hazard free).
// Revision : 1.0  initial release
// ============================================================================
module param_datapath
    import dp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    param_datapath_if.slave       bus
);

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0]  r_regs [NREGS];
    logic [WIDTH-1:0]  r_wb_data;
    logic [AW-1:0]     r_wb_addr;
    logic              r_wb_valid;
    flags_t            r_flags;

    logic [WIDTH-1:0]  w_read_a;
    logic [WIDTH-1:0]  w_read_b;
    logic [WIDTH-1:0]  w_alu_result;
    flags_t            w_alu_flags;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
`ifdef DP_BYPASS_EN
    // The pending writeback wins over the array so a dependent op issued
    // on the very next cycle sees the fresh value.
    assign w_read_a = (r_wb_valid && (r_wb_addr == bus.ra_addr)) ?
                      r_wb_data : r_regs[bus.ra_addr];
    assign w_read_b = (r_wb_valid && (r_wb_addr == bus.rb_addr)) ?
                      r_wb_data : r_regs[bus.rb_addr];
`else
    // Array only: a register being committed reads its old value until
    // the edge, so dependent ops must be spaced by one cycle.
    assign w_read_a = r_regs[bus.ra_addr];
    assign w_read_b = r_regs[bus.rb_addr];
`endif

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    dp_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (w_read_a),
        .b      (w_read_b),
        .opcode (bus.alu_opcode),
        .result (w_alu_result),
        .flags  (w_alu_flags)
    );

    // ------------------------------------------------------------------
    // Issue stage: writeback register and flag register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_data  <= '0;
            r_wb_addr  <= '0;
            r_wb_valid <= 1'b0;
            r_flags    <= '0;
        end else begin
            r_wb_valid <= bus.write_en;
            if (bus.write_en) begin
                r_wb_data <= bus.alu_en ? w_alu_result : bus.user_write_data;
                r_wb_addr <= bus.write_addr;
                if (bus.alu_en) begin
                    r_flags <= w_alu_flags;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit stage: register array
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_wb_valid) begin
            r_regs[r_wb_addr] <= r_wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.read_a    = w_read_a;
    assign bus.read_b    = w_read_b;
    assign bus.wb_data   = r_wb_data;
    assign bus.wb_valid  = r_wb_valid;
    assign bus.alu_zero  = r_flags[FLAG_ZERO];
    assign bus.alu_carry = r_flags[FLAG_CARRY];
    assign bus.alu_neg   = r_flags[FLAG_NEG];
    assign bus.alu_ovf   = r_flags[FLAG_OVF];

endmodule : param_datapath
`default_nettype wire

// File: tb/tb_param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_datapath
// Purpose  : Self-checking bench for param_datapath (WIDTH=8, NREGS=16).
//            Directed scenarios plus randomized traffic, all compared against
//            a cycle-level reference of the register file, pending write and
//            flags. Honours DP_BYPASS_EN in the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_param_datapath;

    localparam int WIDTH = 8;
    localparam int NREGS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    param_datapath_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

    param_datapath #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------------
    // Reference state
    // ------------------------------------------------------------------
    int m_regs [NREGS];
    bit m_wb_valid;
    int m_wb_data;
    int m_wb_addr;
    bit m_z, m_c, m_n, m_v;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int mread(input int addr);
`ifdef DP_BYPASS_EN
        if (m_wb_valid && m_wb_addr == addr) return m_wb_data;
`endif
        return m_regs[addr];
    endfunction

    // Arithmetic reference: plain integer math on unsigned 8-bit values.
    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int r, output bit c, output bit v);
        bit sa, sb, sr;
        c = 0; v = 0;
        sa = (a >= 128); sb = (b >= 128);
        case (op)
            0: begin r = (a + b) % 256; c = (a + b) >= 256; end
            1: begin r = (a - b + 256) % 256; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = (a * 2) % 256; c = (a >= 128); end
            default: begin r = a / 2; c = (a % 2) == 1; end
        endcase
        sr = (r >= 128);
        if (op == 0) v = (sa == sb) && (sr != sa);
        if (op == 1) v = (sa != sb) && (sr != sa);
    endfunction

    // One clock cycle: drive inputs, check reads, advance model, check pipe.
    task automatic step(input bit we, input bit ae, input int op, input int wd,
                        input int wa, input int ra, input int rb);
        int ea, eb, r;
        bit c, v;
        @(negedge clk);
        bus.write_en        = we;
        bus.alu_en          = ae;
        bus.alu_opcode      = 3'(op);
        bus.user_write_data = 8'(wd);
        bus.write_addr      = 4'(wa);
        bus.ra_addr         = 4'(ra);
        bus.rb_addr         = 4'(rb);
        #1;
        ea = mread(ra);
        eb = mread(rb);
        check("read_a", 32'(bus.read_a), 32'(ea));
        check("read_b", 32'(bus.read_b), 32'(eb));
        ref_alu(op, ea, eb, r, c, v);
        @(posedge clk);
        if (m_wb_valid) m_regs[m_wb_addr] = m_wb_data;
        m_wb_valid = we;
        if (we) begin
            m_wb_data = ae ? r : wd;
            m_wb_addr = wa;
            if (ae) begin
                m_z = (r == 0); m_c = c; m_n = (r >= 128); m_v = v;
            end
        end
        #1;
        check("wb_valid", 32'(bus.wb_valid), 32'(m_wb_valid));
        if (we) check("wb_data", 32'(bus.wb_data), 32'(m_wb_data));
        check("flags", {28'd0, bus.alu_ovf, bus.alu_neg, bus.alu_carry, bus.alu_zero},
              {28'd0, m_v, m_n, m_c, m_z});
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.write_en = 1'b0;
        bus.alu_en   = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
        m_wb_valid = 0; m_wb_data = 0; m_wb_addr = 0;
        m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int ra, input int rb);
        step(0, 0, 0, 0, 0, ra, rb);
    endtask

    initial begin
        bus.write_en = 0; bus.alu_en = 0; bus.alu_opcode = 0;
        bus.user_write_data = 0; bus.write_addr = 0;
        bus.ra_addr = 0; bus.rb_addr = 0;
        repeat (2) @(posedge clk);
        do_reset();

        // Reset state
        check("rst_wb_valid", 32'(bus.wb_valid), 0);
        check("rst_flags", {28'd0, bus.alu_ovf, bus.alu_neg, bus.alu_carry, bus.alu_zero}, 0);

        // 1. user writes reg i = i*0x11, then cross sweep
        for (int i = 0; i < 16; i++) step(1, 0, 0, i * 17, i, 0, 0);
        idle(0, 0); idle(0, 0);
        for (int i = 0; i < 16; i++) begin
            idle(i, 15 - i);
            check("t1_read_a", 32'(bus.read_a), 32'(i * 17));
            check("t1_read_b", 32'(bus.read_b), 32'((15 - i) * 17));
        end
        check("t1_flags", {28'd0, bus.alu_ovf, bus.alu_neg, bus.alu_carry, bus.alu_zero}, 0);

        // 2. write_en low must not write
        step(0, 0, 0, 8'h11, 5, 5, 5);
        idle(5, 5);
        check("t2_reg5", 32'(bus.read_a), 32'h55);
        check("t2_wb_valid", 32'(bus.wb_valid), 0);

        // 3. accumulate reg0 += reg1 for 64 cycles
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        idle(0, 1); idle(0, 1);
        for (int i = 0; i < 64; i++) step(1, 1, 0, 0, 0, 0, 1);
        idle(0, 1); idle(0, 1);
`ifdef DP_BYPASS_EN
        check("t3_reg0", 32'(bus.read_a), 32'h40);
`else
        check("t3_reg0", 32'(bus.read_a), 32'h20);
`endif
        check("t3_zero", 32'(bus.alu_zero), 0);
        check("t3_carry", 32'(bus.alu_carry), 0);

        // 4. repeated subtract reg12 -= reg6 for 25 cycles
        step(1, 0, 0, 8'h7F, 12, 0, 0);
        step(1, 0, 0, 8'h0A, 6, 0, 0);
        idle(12, 6); idle(12, 6);
        for (int i = 0; i < 25; i++) step(1, 1, 1, 0, 12, 12, 6);
        idle(12, 6); idle(12, 6);
`ifdef DP_BYPASS_EN
        check("t4_reg12", 32'(bus.read_a), 32'h85);
        check("t4_carry", 32'(bus.alu_carry), 0);
`else
        check("t4_reg12", 32'(bus.read_a), 32'hFD);
        check("t4_carry", 32'(bus.alu_carry), 1);
`endif
        check("t4_neg", 32'(bus.alu_neg), 1);
        check("t4_ovf", 32'(bus.alu_ovf), 0);

        // 5. flag corner cases
        step(1, 0, 0, 8'h7F, 2, 0, 0);
        step(1, 0, 0, 8'h01, 3, 0, 0);
        step(1, 0, 0, 8'hFF, 4, 0, 0);
        step(1, 0, 0, 8'h81, 7, 0, 0);
        idle(0, 0); idle(0, 0);
        step(1, 1, 0, 0, 8, 2, 3);
        check("t5_add_ovf_r", 32'(bus.wb_data), 32'h80);
        check("t5_add_ovf_v", 32'(bus.alu_ovf), 1);
        check("t5_add_ovf_n", 32'(bus.alu_neg), 1);
        step(1, 1, 0, 0, 9, 4, 3);
        check("t5_add_wrap_r", 32'(bus.wb_data), 32'h00);
        check("t5_add_wrap_z", 32'(bus.alu_zero), 1);
        check("t5_add_wrap_c", 32'(bus.alu_carry), 1);
        step(1, 1, 6, 0, 10, 7, 0);
        check("t5_shl_r", 32'(bus.wb_data), 32'h02);
        check("t5_shl_c", 32'(bus.alu_carry), 1);
        // ALU op without write_en leaves flags untouched
        step(0, 1, 0, 0, 11, 4, 3);
        check("t5_hold_c", 32'(bus.alu_carry), 1);

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 255),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15));
        end

        // 6. pending write discarded by reset
        step(1, 1, 0, 8'hAB, 9, 4, 3);
        do_reset();
        #1;
        check("t6_wb_valid", 32'(bus.wb_valid), 0);
        check("t6_flags", {28'd0, bus.alu_ovf, bus.alu_neg, bus.alu_carry, bus.alu_zero}, 0);
        for (int i = 0; i < 16; i++) begin
            idle(i, 15 - i);
            check("t6_reg", 32'(bus.read_a), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_param_datapath
`default_nettype wire
